lsb_queue: RTL and testbench

- Parametrised load/store queue between dispatch and the memory controller.
- Entries are held in program order and snoop two result buses for base address and store data.
- Memory requests issue strictly from the oldest entry. Stores issue only after ROB commit; load results go out on the broadcast bus.
- Adds configurable depth, tag width and dual-bus snooping, plus a full flag and rollback that preserves already-committed stores.

---
 rtl/lsb_queue.sv | 240 ++++++++++++++++++++++++
 tb/tb_lsb_queue.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsb_queue.sv
// lsb_queue: program-ordered load/store queue; snoops two CDBs, issues to memory from the oldest entry only.
// Optional LSB_IO_GUARD_EN: loads hitting the IO window (addr[17:16]==2'b11) wait until they head the ROB.
module lsb_queue #(
   parameter int DEPTH = 16,
   parameter int ROB_W = 4,
   parameter int XLEN  = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             rdy,
   input  logic             rollback,
   output logic             full,
   output logic             empty,
   input  logic             in_valid,
   input  logic             in_store,
   input  logic [2:0]       in_width,
   input  logic [ROB_W-1:0] in_rob,
   input  logic [XLEN-1:0]  in_rs1_val,
   input  logic             in_rs1_pend,
   input  logic [ROB_W-1:0] in_rs1_rob,
   input  logic [XLEN-1:0]  in_rs2_val,
   input  logic             in_rs2_pend,
   input  logic [ROB_W-1:0] in_rs2_rob,
   input  logic [XLEN-1:0]  in_imm,
   input  logic             cdb0_valid,
   input  logic [ROB_W-1:0] cdb0_rob,
   input  logic [XLEN-1:0]  cdb0_value,
   input  logic             cdb1_valid,
   input  logic [ROB_W-1:0] cdb1_rob,
   input  logic [XLEN-1:0]  cdb1_value,
   input  logic             commit_valid,
   input  logic [ROB_W-1:0] commit_rob,
   input  logic [ROB_W-1:0] rob_head,
   output logic             mem_req_valid,
   output logic             mem_req_store,
   output logic [XLEN-1:0]  mem_req_addr,
   output logic [XLEN-1:0]  mem_req_data,
   output logic [2:0]       mem_req_width,
   input  logic             mem_done,
   input  logic [XLEN-1:0]  mem_rdata,
   output logic             bc_valid,
   output logic [ROB_W-1:0] bc_rob,
   output logic [XLEN-1:0]  bc_value
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] ONE = (AW+1)'(1);
   localparam logic [0:0] S_IDLE = 1'b0;
   localparam logic [0:0] S_WAIT = 1'b1;

   typedef struct packed {
      logic             store;
      logic [2:0]       width;
      logic [ROB_W-1:0] rob;
      logic [XLEN-1:0]  rs1;
      logic             rs1_pend;
      logic [ROB_W-1:0] rs1_rob;
      logic [XLEN-1:0]  rs2;
      logic             rs2_pend;
      logic [ROB_W-1:0] rs2_rob;
      logic [XLEN-1:0]  imm;
      logic             cmt;
   } ent_t;

   ent_t             ent_q [DEPTH];
   ent_t             ent_d [DEPTH];
   logic [AW:0]      old_q, old_d, new_q, new_d, ncommit_q, ncommit_d, count, cmt_cnt;
   logic [0:0]       state_q, state_d;
   logic             drop_q, drop_d, req_vld_q, req_vld_d, req_store_q, req_store_d;
   logic [XLEN-1:0]  req_addr_q, req_addr_d, req_data_q, req_data_d;
   logic [2:0]       req_width_q, req_width_d;
   logic [ROB_W-1:0] req_rob_q, req_rob_d, bc_rob_q, bc_rob_d;
   logic             bc_vld_q, bc_vld_d;
   logic [XLEN-1:0]  bc_val_q, bc_val_d;
   logic [DEPTH-1:0] live;
   logic [AW-1:0]    slot;
   ent_t             head;
   logic [XLEN-1:0]  head_addr;
   logic             ld_ok, head_rdy, pop;

   assign count = new_q - old_q;
   assign full  = (count == (AW+1)'(DEPTH));
   assign empty = (count == '0);

   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         live[i] = ({1'b0, AW'(i) - old_q[AW-1:0]} < count);
      end
   end

   assign head      = ent_q[old_q[AW-1:0]];
   assign head_addr = head.rs1 + head.imm;
`ifdef LSB_IO_GUARD_EN
   assign ld_ok = (head_addr[17:16] != 2'b11) || (rob_head == head.rob);
`else
   logic unused_rob_head;
   assign unused_rob_head = ^rob_head;
   assign ld_ok = 1'b1;
`endif
   assign head_rdy = head.store ? (!head.rs1_pend && !head.rs2_pend && head.cmt)
                                : (!head.rs1_pend && ld_ok);

   always_comb begin
      ent_d       = ent_q;
      old_d       = old_q;
      new_d       = new_q;
      state_d     = state_q;
      drop_d      = drop_q;
      req_vld_d   = req_vld_q;
      req_store_d = req_store_q;
      req_addr_d  = req_addr_q;
      req_data_d  = req_data_q;
      req_width_d = req_width_q;
      req_rob_d   = req_rob_q;
      bc_vld_d    = 1'b0;
      bc_rob_d    = bc_rob_q;
      bc_val_d    = bc_val_q;
      cmt_cnt     = '0;
      slot        = new_q[AW-1:0];
      pop         = 1'b0;

      // Snoop both result buses (cdb0 has priority) and mark committed stores.
      for (int i = 0; i < DEPTH; i++) begin
         if (live[i]) begin
            if (ent_q[i].rs1_pend && cdb0_valid && cdb0_rob == ent_q[i].rs1_rob) begin
               ent_d[i].rs1 = cdb0_value;  ent_d[i].rs1_pend = 1'b0;
            end else if (ent_q[i].rs1_pend && cdb1_valid && cdb1_rob == ent_q[i].rs1_rob) begin
               ent_d[i].rs1 = cdb1_value;  ent_d[i].rs1_pend = 1'b0;
            end
            if (ent_q[i].rs2_pend && cdb0_valid && cdb0_rob == ent_q[i].rs2_rob) begin
               ent_d[i].rs2 = cdb0_value;  ent_d[i].rs2_pend = 1'b0;
            end else if (ent_q[i].rs2_pend && cdb1_valid && cdb1_rob == ent_q[i].rs2_rob) begin
               ent_d[i].rs2 = cdb1_value;  ent_d[i].rs2_pend = 1'b0;
            end
            if (commit_valid && ent_q[i].store && !ent_q[i].cmt && ent_q[i].rob == commit_rob) begin
               ent_d[i].cmt = 1'b1;
               cmt_cnt      = cmt_cnt + ONE;
            end
         end
      end

      if (state_q == S_IDLE) begin
         if (!empty && head_rdy && !rollback) begin
            state_d     = S_WAIT;
            req_vld_d   = 1'b1;
            req_store_d = head.store;
            req_addr_d  = head_addr;
            req_data_d  = head.rs2;
            req_width_d = head.width;
            req_rob_d   = head.rob;
         end
      end else if (mem_done) begin
         state_d   = S_IDLE;
         req_vld_d = 1'b0;
         pop       = 1'b1;
         old_d     = old_q + ONE;
         drop_d    = 1'b0;
         if (!req_store_q && !drop_q && !rollback) begin
            bc_vld_d = 1'b1;
            bc_rob_d = req_rob_q;
            bc_val_d = mem_rdata;
         end
      end

      ncommit_d = ncommit_q + cmt_cnt - ((pop && req_store_q) ? ONE : '0);

      // An in-flight load still occupies the oldest slot until memory answers.
      if (rollback) begin
         drop_d = (state_q == S_WAIT) && !req_store_q && !pop;
         new_d  = old_d + ncommit_d + (drop_d ? ONE : '0);
      end else if (in_valid && !full) begin
         new_d                = new_q + ONE;
         ent_d[slot].store    = in_store;
         ent_d[slot].width    = in_width;
         ent_d[slot].rob      = in_rob;
         ent_d[slot].imm      = in_imm;
         ent_d[slot].cmt      = 1'b0;
         ent_d[slot].rs1_rob  = in_rs1_rob;
         ent_d[slot].rs2_rob  = in_rs2_rob;
         ent_d[slot].rs1      = in_rs1_val;
         ent_d[slot].rs1_pend = in_rs1_pend;
         ent_d[slot].rs2      = in_rs2_val;
         ent_d[slot].rs2_pend = in_rs2_pend;
         if (in_rs1_pend && cdb0_valid && cdb0_rob == in_rs1_rob) begin
            ent_d[slot].rs1 = cdb0_value;  ent_d[slot].rs1_pend = 1'b0;
         end else if (in_rs1_pend && cdb1_valid && cdb1_rob == in_rs1_rob) begin
            ent_d[slot].rs1 = cdb1_value;  ent_d[slot].rs1_pend = 1'b0;
         end
         if (in_rs2_pend && cdb0_valid && cdb0_rob == in_rs2_rob) begin
            ent_d[slot].rs2 = cdb0_value;  ent_d[slot].rs2_pend = 1'b0;
         end else if (in_rs2_pend && cdb1_valid && cdb1_rob == in_rs2_rob) begin
            ent_d[slot].rs2 = cdb1_value;  ent_d[slot].rs2_pend = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
         old_q       <= '0;
         new_q       <= '0;
         ncommit_q   <= '0;
         state_q     <= S_IDLE;
         drop_q      <= 1'b0;
         req_vld_q   <= 1'b0;
         req_store_q <= 1'b0;
         req_addr_q  <= '0;
         req_data_q  <= '0;
         req_width_q <= '0;
         req_rob_q   <= '0;
         bc_vld_q    <= 1'b0;
         bc_rob_q    <= '0;
         bc_val_q    <= '0;
      end else if (rdy) begin
         ent_q       <= ent_d;
         old_q       <= old_d;
         new_q       <= new_d;
         ncommit_q   <= ncommit_d;
         state_q     <= state_d;
         drop_q      <= drop_d;
         req_vld_q   <= req_vld_d;
         req_store_q <= req_store_d;
         req_addr_q  <= req_addr_d;
         req_data_q  <= req_data_d;
         req_width_q <= req_width_d;
         req_rob_q   <= req_rob_d;
         bc_vld_q    <= bc_vld_d;
         bc_rob_q    <= bc_rob_d;
         bc_val_q    <= bc_val_d;
      end
   end

   assign mem_req_valid = req_vld_q;
   assign mem_req_store = req_store_q;
   assign mem_req_addr  = req_addr_q;
   assign mem_req_data  = req_data_q;
   assign mem_req_width = req_width_q;
   assign bc_valid      = bc_vld_q;
   assign bc_rob        = bc_rob_q;
   assign bc_value      = bc_val_q;
endmodule

// File: tb/tb_lsb_queue.sv
// Directed bench for lsb_queue (DEPTH=4); expected values are hand-derived per vector.
module tb_lsb_queue;
   localparam int DEPTH = 4;
   localparam int ROB_W = 4;
   localparam int XLEN  = 32;

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic             rdy = 1'b1;
   logic             rollback = 1'b0;
   logic             full, empty;
   logic             in_valid = 1'b0, in_store = 1'b0;
   logic [2:0]       in_width = 3'b010;
   logic [ROB_W-1:0] in_rob = '0, in_rs1_rob = '0, in_rs2_rob = '0;
   logic [XLEN-1:0]  in_rs1_val = '0, in_rs2_val = '0, in_imm = '0;
   logic             in_rs1_pend = 1'b0, in_rs2_pend = 1'b0;
   logic             cdb0_valid = 1'b0, cdb1_valid = 1'b0;
   logic [ROB_W-1:0] cdb0_rob = '0, cdb1_rob = '0;
   logic [XLEN-1:0]  cdb0_value = '0, cdb1_value = '0;
   logic             commit_valid = 1'b0;
   logic [ROB_W-1:0] commit_rob = '0, rob_head = '0;
   logic             mem_req_valid, mem_req_store;
   logic [XLEN-1:0]  mem_req_addr, mem_req_data;
   logic [2:0]       mem_req_width;
   logic             mem_done = 1'b0;
   logic [XLEN-1:0]  mem_rdata = '0;
   logic             bc_valid;
   logic [ROB_W-1:0] bc_rob;
   logic [XLEN-1:0]  bc_value;

   int n_cmp = 0;
   int n_err = 0;

   lsb_queue #(.DEPTH(DEPTH), .ROB_W(ROB_W), .XLEN(XLEN)) dut (
      .clk(clk), .rst(rst), .rdy(rdy), .rollback(rollback), .full(full), .empty(empty),
      .in_valid(in_valid), .in_store(in_store), .in_width(in_width), .in_rob(in_rob),
      .in_rs1_val(in_rs1_val), .in_rs1_pend(in_rs1_pend), .in_rs1_rob(in_rs1_rob),
      .in_rs2_val(in_rs2_val), .in_rs2_pend(in_rs2_pend), .in_rs2_rob(in_rs2_rob),
      .in_imm(in_imm),
      .cdb0_valid(cdb0_valid), .cdb0_rob(cdb0_rob), .cdb0_value(cdb0_value),
      .cdb1_valid(cdb1_valid), .cdb1_rob(cdb1_rob), .cdb1_value(cdb1_value),
      .commit_valid(commit_valid), .commit_rob(commit_rob), .rob_head(rob_head),
      .mem_req_valid(mem_req_valid), .mem_req_store(mem_req_store), .mem_req_addr(mem_req_addr),
      .mem_req_data(mem_req_data), .mem_req_width(mem_req_width),
      .mem_done(mem_done), .mem_rdata(mem_rdata),
      .bc_valid(bc_valid), .bc_rob(bc_rob), .bc_value(bc_value)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic disp(input logic st, input logic [3:0] rob, input logic [31:0] base,
                       input logic bpend, input logic [3:0] btag, input logic [31:0] data,
                       input logic dpend, input logic [3:0] dtag, input logic [31:0] imm);
      in_valid = 1'b1;  in_store = st;  in_rob = rob;
      in_rs1_val = base;  in_rs1_pend = bpend;  in_rs1_rob = btag;
      in_rs2_val = data;  in_rs2_pend = dpend;  in_rs2_rob = dtag;
      in_imm = imm;
      tick();
      in_valid = 1'b0;
   endtask

   task automatic wait_req(input string tag);
      for (int n = 0; n < 20 && !mem_req_valid; n++) tick();
      check({tag, "_req_vld"}, mem_req_valid, 1);
   endtask

   task automatic serve_ld(input string tag, input logic [31:0] addr, input logic [3:0] rob,
                           input logic [31:0] rdata);
      wait_req(tag);
      check({tag, "_addr"}, mem_req_addr, addr);
      check({tag, "_is_ld"}, mem_req_store, 0);
      mem_done = 1'b1;  mem_rdata = rdata;
      tick();
      mem_done = 1'b0;
      check({tag, "_bc_vld"}, bc_valid, 1);
      check({tag, "_bc_rob"}, bc_rob, rob);
      check({tag, "_bc_val"}, bc_value, rdata);
      tick();
   endtask

   task automatic serve_st(input string tag, input logic [31:0] addr, input logic [31:0] data);
      wait_req(tag);
      check({tag, "_addr"}, mem_req_addr, addr);
      check({tag, "_is_st"}, mem_req_store, 1);
      check({tag, "_data"}, mem_req_data, data);
      mem_done = 1'b1;
      tick();
      mem_done = 1'b0;
      check({tag, "_no_bc"}, bc_valid, 0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      repeat (2) @(posedge clk);
      #1;
      check("rst_empty", empty, 1);
      check("rst_full", full, 0);
      check("rst_req", mem_req_valid, 0);
      check("rst_bc", bc_valid, 0);
      rst = 1'b1;
      tick();

      // Reset while a request is outstanding
      disp(0, 4'd1, 32'h10, 0, 0, 0, 0, 0, 0);
      wait_req("t1");
      rst = 1'b0;
      #1;
      check("t1_req", mem_req_valid, 0);
      check("t1_empty", empty, 1);
      check("t1_bc", bc_valid, 0);
      rst = 1'b1;
      tick();

      // Basic load; request fields hold through WAIT
      disp(0, 4'd1, 32'h1000, 0, 0, 0, 0, 0, 32'd4);
      check("t2_not_empty", empty, 0);
      wait_req("t2");
      check("t2_width", mem_req_width, 3'b010);
      for (int k = 0; k < 3; k++) begin
         tick();
         check("t2_hold_vld", mem_req_valid, 1);
         check("t2_hold_addr", mem_req_addr, 32'h1004);
      end
      serve_ld("t2", 32'h1004, 4'd1, 32'hDEADBEEF);
      check("t2_bc_one_cycle", bc_valid, 0);
      check("t2_empty", empty, 1);

      // Store waits for data snoop on cdb1 and then for commit
      disp(1, 4'd6, 32'h2000, 0, 0, 0, 1, 4'd5, 32'd8);
      tick();  tick();
      check("t3_wait_data", mem_req_valid, 0);
      cdb1_valid = 1'b1;  cdb1_rob = 4'd5;  cdb1_value = 32'h55;
      tick();
      cdb1_valid = 1'b0;
      tick();  tick();
      check("t3_wait_commit", mem_req_valid, 0);
      commit_valid = 1'b1;  commit_rob = 4'd6;
      tick();
      commit_valid = 1'b0;
      serve_st("t3", 32'h2008, 32'h55);
      tick();
      check("t3_empty", empty, 1);

      // Dispatch capture and dual-bus priority
      cdb0_valid = 1'b1;  cdb0_rob = 4'd10;  cdb0_value = 32'h500;
      disp(0, 4'd2, 0, 1, 4'd10, 0, 0, 0, 32'h4);
      cdb0_valid = 1'b0;
      serve_ld("cap", 32'h504, 4'd2, 32'h1);
      disp(0, 4'd12, 0, 1, 4'd11, 0, 0, 0, 32'h10);
      cdb0_valid = 1'b1;  cdb0_rob = 4'd11;  cdb0_value = 32'hA00;
      cdb1_valid = 1'b1;  cdb1_rob = 4'd11;  cdb1_value = 32'hB00;
      tick();
      cdb0_valid = 1'b0;  cdb1_valid = 1'b0;
      serve_ld("prio", 32'hA10, 4'd12, 32'h2);

      // rdy low freezes dispatch and mem_done sampling
      rdy = 1'b0;
      disp(0, 4'd13, 32'h600, 0, 0, 0, 0, 0, 0);
      rdy = 1'b1;
      check("rdy_no_disp", empty, 1);
      disp(0, 4'd13, 32'h600, 0, 0, 0, 0, 0, 0);
      wait_req("rdy");
      rdy = 1'b0;  mem_done = 1'b1;  mem_rdata = 32'h77;
      tick();  tick();
      check("rdy_hold_req", mem_req_valid, 1);
      check("rdy_no_bc", bc_valid, 0);
      rdy = 1'b1;
      tick();
      mem_done = 1'b0;
      check("rdy_bc", bc_valid, 1);
      check("rdy_bc_val", bc_value, 32'h77);
      tick();

      // Fill, drop on full, wrap-around
      for (int i = 1; i <= 4; i++) disp(0, 4'(i), 0, 1, 4'd9, 0, 0, 0, 32'(4 * (i - 1)));
      check("t4_full", full, 1);
      disp(0, 4'd5, 32'h900, 0, 0, 0, 0, 0, 0);
      check("t4_still_full", full, 1);
      cdb0_valid = 1'b1;  cdb0_rob = 4'd9;  cdb0_value = 32'h100;
      tick();
      cdb0_valid = 1'b0;
      serve_ld("t4_r1", 32'h100, 4'd1, 32'h11);
      check("t4_not_full", full, 0);
      disp(0, 4'd6, 32'h200, 0, 0, 0, 0, 0, 32'h0);
      check("t4_full_again", full, 1);
      serve_ld("t4_r2", 32'h104, 4'd2, 32'h12);
      disp(0, 4'd7, 32'h200, 0, 0, 0, 0, 0, 32'h4);
      serve_ld("t4_r3", 32'h108, 4'd3, 32'h13);
      disp(0, 4'd8, 32'h200, 0, 0, 0, 0, 0, 32'h8);
      serve_ld("t4_r4", 32'h10C, 4'd4, 32'h14);
      serve_ld("t4_r6", 32'h200, 4'd6, 32'h16);
      serve_ld("t4_r7", 32'h204, 4'd7, 32'h17);
      serve_ld("t4_r8", 32'h208, 4'd8, 32'h18);
      check("t4_empty", empty, 1);

      // Rollback with a load in flight and two committed stores behind it
      disp(0, 4'd1, 32'h3000, 0, 0, 0, 0, 0, 0);
      disp(0, 4'd2, 32'h3004, 0, 0, 0, 0, 0, 0);
      disp(1, 4'd3, 32'h4000, 0, 0, 32'h11, 0, 0, 0);
      disp(1, 4'd4, 32'h4004, 0, 0, 32'h22, 0, 0, 0);
      serve_ld("t5_lx", 32'h3000, 4'd1, 32'h5);
      disp(0, 4'd5, 32'h3008, 0, 0, 0, 0, 0, 0);
      commit_valid = 1'b1;  commit_rob = 4'd3;
      tick();
      commit_rob = 4'd4;
      tick();
      commit_valid = 1'b0;
      check("t5_ld_inflight", mem_req_addr, 32'h3004);
      rollback = 1'b1;
      disp(0, 4'd6, 32'h3100, 0, 0, 0, 0, 0, 0);
      rollback = 1'b0;
      check("t5_wait_held", mem_req_valid, 1);
      mem_done = 1'b1;
      tick();
      mem_done = 1'b0;
      check("t5_drop_no_bc", bc_valid, 0);
      check("t5_drop_req", mem_req_valid, 0);
      disp(0, 4'd7, 0, 1, 4'd12, 0, 0, 0, 0);
      disp(0, 4'd8, 0, 1, 4'd12, 0, 0, 0, 0);
      check("t5_count2_full", full, 1);
      serve_st("t5_s1", 32'h4000, 32'h11);
      serve_st("t5_s2", 32'h4004, 32'h22);
      tick();  tick();  tick();
      check("t5_no_more_req", mem_req_valid, 0);
      check("t5_pending_left", empty, 0);
      rollback = 1'b1;
      tick();
      rollback = 1'b0;
      check("t5_flushed", empty, 1);

`ifdef LSB_IO_GUARD_EN
      rob_head = 4'd3;
      disp(0, 4'd9, 32'h30000, 0, 0, 0, 0, 0, 0);
      tick();  tick();  tick();
      check("t6_io_held", mem_req_valid, 0);
      rob_head = 4'd9;
      tick();
      check("t6_io_issue", mem_req_valid, 1);
      serve_ld("t6", 32'h30000, 4'd9, 32'h66);
      rob_head = 4'd0;
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
